// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver. Recovers one frame (start, Width data
// bits LSB first, optional parity, one stop bit) and strobes the result.
module uart_rx #(
  parameter int unsigned Width = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rx_in,
  input  logic             i_par_en,
  input  logic             i_par_typ,
  input  logic [5:0]       i_prescale,
  output logic [Width-1:0] o_p_data,
  output logic             o_data_valid,
  output logic             o_par_err,
  output logic             o_stp_err
);

  localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(Width - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // Registered state
  state_e            r_state;
  logic [5:0]        r_edge_cnt;
  logic [CntW-1:0]   r_bit_cnt;
  logic [1:0]        r_samp;
  logic              r_bit;
  logic [Width-1:0]  r_shift;
  logic              r_par_en;
  logic              r_par_typ;
  logic [5:0]        r_presc;
  logic              r_par_fail;
  logic [Width-1:0]  r_p_data;
  logic              r_data_valid;
  logic              r_par_err;
  logic              r_stp_err;

  // Next-state values
  state_e            w_state_d;
  logic [5:0]        w_edge_cnt_d;
  logic [CntW-1:0]   w_bit_cnt_d;
  logic [1:0]        w_samp_d;
  logic              w_bit_d;
  logic [Width-1:0]  w_shift_d;
  logic              w_par_en_d;
  logic              w_par_typ_d;
  logic [5:0]        w_presc_d;
  logic              w_par_fail_d;
  logic [Width-1:0]  w_p_data_d;
  logic              w_data_valid_d;
  logic              w_par_err_d;
  logic              w_stp_err_d;

  // Helpers
  logic [5:0]        w_presc_sel;
  logic [5:0]        w_half;
  logic              w_last_edge;
  logic              w_maj;
  logic              w_par_exp;

  // Unsupported ratios fall back to 8.
  assign w_presc_sel = ((i_prescale == 6'd16) || (i_prescale == 6'd32)) ? i_prescale : 6'd8;
  assign w_half      = r_presc >> 1;
  assign w_last_edge = (r_edge_cnt == (r_presc - 6'd1));
  // Third sample is the live line; the first two were captured earlier in the bit.
  assign w_maj       = (r_samp[0] & r_samp[1]) | (r_samp[0] & i_rx_in) | (r_samp[1] & i_rx_in);
  assign w_par_exp   = r_par_typ ? ~^r_shift : ^r_shift;

  // Next-state and registered-output logic
  always_comb begin
    w_state_d      = r_state;
    w_edge_cnt_d   = r_edge_cnt;
    w_bit_cnt_d    = r_bit_cnt;
    w_samp_d       = r_samp;
    w_bit_d        = r_bit;
    w_shift_d      = r_shift;
    w_par_en_d     = r_par_en;
    w_par_typ_d    = r_par_typ;
    w_presc_d      = r_presc;
    w_par_fail_d   = r_par_fail;
    w_p_data_d     = r_p_data;
    w_data_valid_d = 1'b0;
    w_par_err_d    = 1'b0;
    w_stp_err_d    = 1'b0;

    if (r_state != StIdle) begin
      w_edge_cnt_d = w_last_edge ? 6'd0 : r_edge_cnt + 6'd1;
      if (r_edge_cnt == w_half - 6'd1) w_samp_d[0] = i_rx_in;
      if (r_edge_cnt == w_half)        w_samp_d[1] = i_rx_in;
      if (r_edge_cnt == w_half + 6'd1) w_bit_d     = w_maj;
    end

    unique case (r_state)
      StIdle: begin
        w_edge_cnt_d = 6'd0;
        if (!i_rx_in) begin
          // The detecting cycle is edge 0 of the start bit, so START begins at edge 1.
          w_state_d    = StStart;
          w_edge_cnt_d = 6'd1;
          w_bit_cnt_d  = '0;
          w_par_fail_d = 1'b0;
          w_par_en_d   = i_par_en;
          w_par_typ_d  = i_par_typ;
          w_presc_d    = w_presc_sel;
        end
      end
      StStart: begin
        if (w_last_edge) begin
          w_state_d = r_bit ? StIdle : StData;
        end
      end
      StData: begin
        if (w_last_edge) begin
          w_shift_d[r_bit_cnt] = r_bit;
          if (r_bit_cnt == LastBit) begin
            w_bit_cnt_d = '0;
            w_state_d   = r_par_en ? StParity : StStop;
          end else begin
            w_bit_cnt_d = r_bit_cnt + 1'b1;
          end
        end
      end
      StParity: begin
        if (w_last_edge) begin
          if (r_bit != w_par_exp) w_par_fail_d = 1'b1;
          w_state_d = StStop;
        end
      end
      StStop: begin
        if (w_last_edge) begin
          w_state_d = StIdle;
          if (r_bit && !r_par_fail) begin
            w_p_data_d     = r_shift;
            w_data_valid_d = 1'b1;
          end else begin
            w_stp_err_d = ~r_bit;
            w_par_err_d = r_par_fail;
          end
        end
      end
      default: begin
        w_state_d    = StIdle;
        w_edge_cnt_d = 6'd0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_edge_cnt   <= 6'd0;
      r_bit_cnt    <= '0;
      r_samp       <= 2'b11;
      r_bit        <= 1'b1;
      r_shift      <= '0;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_presc      <= 6'd8;
      r_par_fail   <= 1'b0;
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_edge_cnt   <= w_edge_cnt_d;
      r_bit_cnt    <= w_bit_cnt_d;
      r_samp       <= w_samp_d;
      r_bit        <= w_bit_d;
      r_shift      <= w_shift_d;
      r_par_en     <= w_par_en_d;
      r_par_typ    <= w_par_typ_d;
      r_presc      <= w_presc_d;
      r_par_fail   <= w_par_fail_d;
      r_p_data     <= w_p_data_d;
      r_data_valid <= w_data_valid_d;
      r_par_err    <= w_par_err_d;
      r_stp_err    <= w_stp_err_d;
    end
  end

  assign o_p_data     = r_p_data;
  assign o_data_valid = r_data_valid;
  assign o_par_err    = r_par_err;
  assign o_stp_err    = r_stp_err;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       par_en;
  logic       par_typ;
  logic [5:0] prescale;
  logic [7:0] p_data;
  logic       dv;
  logic       pe;
  logic       se;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         dv_cyc_q[$];
  logic [7:0] dv_dat_q[$];
  int         pe_cyc_q[$];
  int         se_cyc_q[$];

  uart_rx #(.Width(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rx_in      (rx),
    .i_par_en     (par_en),
    .i_par_typ    (par_typ),
    .i_prescale   (prescale),
    .o_p_data     (p_data),
    .o_data_valid (dv),
    .o_par_err    (pe),
    .o_stp_err    (se)
  );

  always #5 clk = ~clk;

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (dv) begin
      dv_cyc_q.push_back(cyc);
      dv_dat_q.push_back(p_data);
    end
    if (pe) pe_cyc_q.push_back(cyc);
    if (se) se_cyc_q.push_back(cyc);
  end

  // Drive one bit for n clocks; returns 1 time unit after a rising edge.
  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input int n, input logic with_par,
                            input logic par_bit, input logic stop_bit);
    drive_bit(1'b0, n);
    for (int i = 0; i < 8; i++) drive_bit(data[i], n);
    if (with_par) drive_bit(par_bit, n);
    drive_bit(stop_bit, n);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    par_en = 1'b0;
    par_typ = 1'b0;
    prescale = 6'd8;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (p_data !== 8'h00) begin errors++; $display("FAIL reset_p_data: got %h want 00", p_data); end
    checks++; if (dv !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b want 0", dv); end
    checks++; if (pe !== 1'b0) begin errors++; $display("FAIL reset_pe: got %b want 0", pe); end
    checks++; if (se !== 1'b0) begin errors++; $display("FAIL reset_se: got %b want 0", se); end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_basic_p8();
    int s, nd, np, ns;
    nd = dv_cyc_q.size(); np = pe_cyc_q.size(); ns = se_cyc_q.size();
    prescale = 6'd8; par_en = 1'b0;
    s = cyc;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (dv_cyc_q.size() != nd + 1) begin errors++; $display("FAIL basic_dv_count: got %0d want 1", dv_cyc_q.size() - nd); end
    checks++; if (dv_cyc_q.size() <= nd || dv_cyc_q[nd] != s + 80) begin errors++; $display("FAIL basic_dv_cycle: got %0d want 80", (dv_cyc_q.size() > nd) ? dv_cyc_q[nd] - s : -1); end
    checks++; if (p_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", p_data); end
    checks++; if (pe_cyc_q.size() != np) begin errors++; $display("FAIL basic_no_pe: got %0d want 0", pe_cyc_q.size() - np); end
    checks++; if (se_cyc_q.size() != ns) begin errors++; $display("FAIL basic_no_se: got %0d want 0", se_cyc_q.size() - ns); end
  endtask

  task automatic test_parity_p16();
    int s, nd, np, ns;
    prescale = 6'd16; par_en = 1'b1; par_typ = 1'b0;
    // 0x3C has four ones: even parity bit is 0.
    nd = dv_cyc_q.size(); np = pe_cyc_q.size();
    s = cyc;
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (dv_cyc_q.size() <= nd || dv_cyc_q[nd] != s + 176) begin errors++; $display("FAIL par_good_dv_cycle: got %0d want 176", (dv_cyc_q.size() > nd) ? dv_cyc_q[nd] - s : -1); end
    checks++; if (p_data !== 8'h3C) begin errors++; $display("FAIL par_good_data: got %h want 3c", p_data); end
    checks++; if (pe_cyc_q.size() != np) begin errors++; $display("FAIL par_good_no_pe: got %0d want 0", pe_cyc_q.size() - np); end
    nd = dv_cyc_q.size(); np = pe_cyc_q.size(); ns = se_cyc_q.size();
    s = cyc;
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (pe_cyc_q.size() != np + 1 || pe_cyc_q[np] != s + 176) begin errors++; $display("FAIL par_bad_pe: got count %0d want one strobe at 176", pe_cyc_q.size() - np); end
    checks++; if (dv_cyc_q.size() != nd) begin errors++; $display("FAIL par_bad_no_dv: got %0d want 0", dv_cyc_q.size() - nd); end
    checks++; if (se_cyc_q.size() != ns) begin errors++; $display("FAIL par_bad_no_se: got %0d want 0", se_cyc_q.size() - ns); end
    checks++; if (p_data !== 8'h3C) begin errors++; $display("FAIL par_bad_hold: got %h want 3c", p_data); end
  endtask

  task automatic test_stop_err_p32();
    int s, nd, np, ns;
    prescale = 6'd32; par_en = 1'b1; par_typ = 1'b1;
    nd = dv_cyc_q.size(); np = pe_cyc_q.size(); ns = se_cyc_q.size();
    s = cyc;
    // 0x01 has one one: odd parity bit is 0, so only the stop bit is bad.
    send_frame(8'h01, 32, 1'b1, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (se_cyc_q.size() != ns + 1 || se_cyc_q[ns] != s + 352) begin errors++; $display("FAIL stop_se: got count %0d want one strobe at 352", se_cyc_q.size() - ns); end
    checks++; if (dv_cyc_q.size() != nd) begin errors++; $display("FAIL stop_no_dv: got %0d want 0", dv_cyc_q.size() - nd); end
    checks++; if (pe_cyc_q.size() != np) begin errors++; $display("FAIL stop_no_pe: got %0d want 0", pe_cyc_q.size() - np); end
    checks++; if (p_data !== 8'h3C) begin errors++; $display("FAIL stop_hold: got %h want 3c", p_data); end
  endtask

  task automatic test_glitch();
    int s, nd, np, ns;
    prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
    nd = dv_cyc_q.size(); np = pe_cyc_q.size(); ns = se_cyc_q.size();
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 20);
    checks++; if (dv_cyc_q.size() + pe_cyc_q.size() + se_cyc_q.size() != nd + np + ns) begin errors++; $display("FAIL glitch_no_strobe: got %0d strobes want 0", dv_cyc_q.size() + pe_cyc_q.size() + se_cyc_q.size() - nd - np - ns); end
    s = cyc;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (dv_cyc_q.size() != nd + 1 || dv_cyc_q[nd] != s + 80) begin errors++; $display("FAIL glitch_next_dv: got count %0d want one strobe at 80", dv_cyc_q.size() - nd); end
    checks++; if (p_data !== 8'h5A) begin errors++; $display("FAIL glitch_next_data: got %h want 5a", p_data); end
    checks++; if (se_cyc_q.size() != ns) begin errors++; $display("FAIL glitch_no_se: got %0d want 0", se_cyc_q.size() - ns); end
  endtask

  task automatic test_back_to_back();
    int s, nd;
    prescale = 6'd8; par_en = 1'b0;
    nd = dv_cyc_q.size();
    s = cyc;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'hEE, 8, 1'b0, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (dv_cyc_q.size() != nd + 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", dv_cyc_q.size() - nd); end
    if (dv_cyc_q.size() >= nd + 2) begin
      checks++; if (dv_cyc_q[nd] != s + 80) begin errors++; $display("FAIL b2b_first_cycle: got %0d want 80", dv_cyc_q[nd] - s); end
      checks++; if (dv_dat_q[nd] !== 8'h11) begin errors++; $display("FAIL b2b_first_data: got %h want 11", dv_dat_q[nd]); end
      checks++; if (dv_cyc_q[nd+1] - dv_cyc_q[nd] != 80) begin errors++; $display("FAIL b2b_spacing: got %0d want 80", dv_cyc_q[nd+1] - dv_cyc_q[nd]); end
      checks++; if (dv_dat_q[nd+1] !== 8'hEE) begin errors++; $display("FAIL b2b_second_data: got %h want ee", dv_dat_q[nd+1]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int s, nd, np, ns;
    prescale = 6'd8; par_en = 1'b0;
    nd = dv_cyc_q.size(); np = pe_cyc_q.size(); ns = se_cyc_q.size();
    // Start bit plus a few data bits, then reset in the middle of DATA.
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 20);
    rst_n = 1'b0;
    #1;
    checks++; if (p_data !== 8'h00) begin errors++; $display("FAIL mid_rst_p_data: got %h want 00", p_data); end
    checks++; if (dv !== 1'b0 || pe !== 1'b0 || se !== 1'b0) begin errors++; $display("FAIL mid_rst_strobes: got %b%b%b want 000", dv, pe, se); end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    checks++; if (dv_cyc_q.size() + pe_cyc_q.size() + se_cyc_q.size() != nd + np + ns) begin errors++; $display("FAIL mid_rst_aborted: got %0d strobes want 0", dv_cyc_q.size() + pe_cyc_q.size() + se_cyc_q.size() - nd - np - ns); end
    s = cyc;
    send_frame(8'h7F, 8, 1'b0, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (dv_cyc_q.size() != nd + 1 || dv_cyc_q[nd] != s + 80) begin errors++; $display("FAIL mid_rst_next_dv: got count %0d want one strobe at 80", dv_cyc_q.size() - nd); end
    checks++; if (p_data !== 8'h7F) begin errors++; $display("FAIL mid_rst_next_data: got %h want 7f", p_data); end
  endtask

  initial begin
    test_reset();
    test_basic_p8();
    test_parity_p16();
    test_stop_err_p32();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
